// File: rtl/operand_fetch.sv
// operand_fetch: upstream operand stage for the 16-bit ALU.
// Reads two 16-bit operands, each as two bytes, from an 8-bit memory with a
// fixed 1-cycle read latency. It then holds the pair on a valid/ready handshake
// until the ALU accepts it. One request is in flight at a time.
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   req_valid/req_ready    request handshake; src1_addr/src2_addr latched on accept
//   mem_rd/mem_addr        memory read strobe and byte address
//   mem_rdata              read data, valid on the edge after the mem_rd cycle
//   op1/op2                assembled operands (registered)
//   op_valid/op_ready      operand handshake towards the ALU
module operand_fetch #(
    parameter int unsigned ADDR_W     = 16,
    parameter bit          BIG_ENDIAN = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] src1_addr,
    input  logic [ADDR_W-1:0] src2_addr,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [7:0]        mem_rdata,
    output logic [15:0]       op1,
    output logic [15:0]       op2,
    output logic              op_valid,
    input  logic              op_ready
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A1L   = 3'd1,
        A1H   = 3'd2,
        A2L   = 3'd3,
        A2H   = 3'd4,
        LAST  = 3'd5,
        VALID = 3'd6
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;

    // Place a byte into its lane: byte0 is the byte at addr, byte1 at addr+1.
    function automatic logic [15:0] put_byte(input logic [15:0] word,
                                             input logic        byte1,
                                             input logic [7:0]  data);
        logic [15:0] w;
        w = word;
        if (byte1 ^ BIG_ENDIAN) w[15:8] = data;
        else                    w[7:0]  = data;
        return w;
    endfunction

    // Address of the second byte; wraps modulo 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
        return ADDR_W'(a + ADDR_W'(1));
    endfunction

    // FSM with registered outputs: each transition also loads the outputs of
    // the state being entered. Read data for a mem_rd cycle is captured on the
    // exit edge of the following state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            a1        <= '0;
            a2        <= '0;
            req_ready <= 1'b1;
            mem_rd    <= 1'b0;
            mem_addr  <= '0;
            op1       <= '0;
            op2       <= '0;
            op_valid  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        a1        <= src1_addr;
                        a2        <= src2_addr;
                        req_ready <= 1'b0;
                        mem_rd    <= 1'b1;
                        mem_addr  <= src1_addr;
                        state     <= A1L;
                    end
                end
                A1L: begin
                    mem_addr <= next_addr(a1);
                    state    <= A1H;
                end
                A1H: begin
                    op1      <= put_byte(op1, 1'b0, mem_rdata);
                    mem_addr <= a2;
                    state    <= A2L;
                end
                A2L: begin
                    op1      <= put_byte(op1, 1'b1, mem_rdata);
                    mem_addr <= next_addr(a2);
                    state    <= A2H;
                end
                A2H: begin
                    op2    <= put_byte(op2, 1'b0, mem_rdata);
                    mem_rd <= 1'b0;
                    state  <= LAST;
                end
                LAST: begin
                    op2      <= put_byte(op2, 1'b1, mem_rdata);
                    op_valid <= 1'b1;
                    state    <= VALID;
                end
                VALID: begin
                    if (op_ready) begin
                        op_valid  <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    req_ready <= 1'b1;
                    mem_rd    <= 1'b0;
                    op_valid  <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_operand_fetch.sv
// tb_operand_fetch: self-checking bench for operand_fetch.
// Runs a little-endian and a big-endian instance in lockstep on a shared
// byte-memory model, drives a table of requests and checks the results against
// a scoreboard of expected operand pairs.
module tb_operand_fetch;

    localparam int unsigned ADDR_W = 16;

    typedef struct packed {
        logic [15:0] s1;
        logic [15:0] s2;
        logic [15:0] op1;
        logic [15:0] op2;
        logic [15:0] be1;
        logic [15:0] be2;
    } vec_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req_valid;
    logic [ADDR_W-1:0] src1_addr;
    logic [ADDR_W-1:0] src2_addr;
    logic              op_ready;
    logic [7:0]        mem_rdata;

    logic              req_ready, mem_rd, op_valid;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       op1, op2;
    logic              be_req_ready, be_mem_rd, be_op_valid;
    logic [ADDR_W-1:0] be_mem_addr;
    logic [15:0]       be_op1, be_op2;

    logic [7:0] mem [0:65535];
    vec_t       sb[$];
    vec_t       vecs[5];
    vec_t       last_exp;
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    operand_fetch #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .src1_addr(src1_addr), .src2_addr(src2_addr),
        .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
        .op1(op1), .op2(op2), .op_valid(op_valid), .op_ready(op_ready)
    );

    operand_fetch #(.ADDR_W(ADDR_W), .BIG_ENDIAN(1'b1)) dut_be (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(be_req_ready),
        .src1_addr(src1_addr), .src2_addr(src2_addr),
        .mem_rd(be_mem_rd), .mem_addr(be_mem_addr), .mem_rdata(mem_rdata),
        .op1(be_op1), .op2(be_op2), .op_valid(be_op_valid), .op_ready(op_ready)
    );

    // Byte memory with a 1-cycle registered read.
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_addr];
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive a request in IDLE and push its expected result.
    task automatic issue(input vec_t v);
        @(negedge clk);
        chk1("req_ready_idle", req_ready, 1'b1);
        req_valid = 1'b1;
        src1_addr = v.s1;
        src2_addr = v.s2;
        sb.push_back(v);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        src1_addr = 16'($urandom);
        src2_addr = 16'($urandom);
    endtask

    // Follow a request from A1L into VALID, then optionally hold backpressure.
    task automatic follow(input vec_t v, input int hold);
        vec_t exp;
        int   n;
        logic [15:0] addrs [4];
        addrs[0] = v.s1;
        addrs[1] = 16'(v.s1 + 16'd1);
        addrs[2] = v.s2;
        addrs[3] = 16'(v.s2 + 16'd1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk1("mem_rd_fetch", mem_rd, 1'b1);
            chk16("mem_addr_seq", mem_addr, addrs[k]);
            chk16("be_mem_addr_seq", be_mem_addr, addrs[k]);
            chk1("op_valid_early", op_valid, 1'b0);
        end
        @(negedge clk);
        chk1("mem_rd_last", mem_rd, 1'b0);
        chk1("op_valid_last", op_valid, 1'b0);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!op_valid && n < 8);
        chk1("op_valid_rise", op_valid, 1'b1);
        chk16("op_valid_latency", 16'(n), 16'd1);
        exp = '0;
        if (sb.size() == 0) begin
            errors++;
            checks++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
        end else begin
            exp = sb.pop_front();
        end
        chk16("op1", op1, exp.op1);
        chk16("op2", op2, exp.op2);
        chk16("be_op1", be_op1, exp.be1);
        chk16("be_op2", be_op2, exp.be2);
        chk1("req_ready_valid", req_ready, 1'b0);
        for (int k = 0; k < hold; k++) begin
            req_valid = 1'($urandom_range(0, 1));
            src1_addr = 16'($urandom);
            src2_addr = 16'($urandom);
            @(negedge clk);
            chk1("bp_op_valid", op_valid, 1'b1);
            chk1("bp_req_ready", req_ready, 1'b0);
            chk1("bp_mem_rd", mem_rd, 1'b0);
            chk16("bp_op1", op1, exp.op1);
            chk16("bp_op2", op2, exp.op2);
        end
        req_valid = 1'b0;
        last_exp  = exp;
    endtask

    // Transfer from VALID, then check return to IDLE with operands held.
    task automatic transfer();
        op_ready = 1'b1;
        @(posedge clk);
        #1;
        op_ready = 1'b0;
        @(negedge clk);
        chk1("post_op_valid", op_valid, 1'b0);
        chk1("post_req_ready", req_ready, 1'b1);
        chk16("post_op1_hold", op1, last_exp.op1);
        chk16("post_op2_hold", op2, last_exp.op2);
    endtask

    // Transfer with req_valid already high: accept lands on the next edge.
    task automatic back_to_back(input vec_t v);
        op_ready  = 1'b1;
        req_valid = 1'b1;
        src1_addr = v.s1;
        src2_addr = v.s2;
        @(posedge clk);
        @(negedge clk);
        chk1("b2b_idle_ready", req_ready, 1'b1);
        chk1("b2b_op_valid", op_valid, 1'b0);
        chk1("b2b_mem_rd", mem_rd, 1'b0);
        sb.push_back(v);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        op_ready  = 1'b0;
        src1_addr = 16'($urandom);
        src2_addr = 16'($urandom);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 3);
        mem[16'h0004] = 8'h34; mem[16'h0005] = 8'h12;
        mem[16'h0006] = 8'h77;
        mem[16'h0008] = 8'hCD; mem[16'h0009] = 8'hAB;
        mem[16'h000A] = 8'h3C;
        mem[16'hFFFF] = 8'h11; mem[16'h0000] = 8'h22;
        mem[16'h0002] = 8'h5A; mem[16'h0003] = 8'hA5;

        //          s1        s2        op1       op2       be1       be2
        vecs[0] = {16'h0004, 16'h0008, 16'h1234, 16'hABCD, 16'h3412, 16'hCDAB};
        vecs[1] = {16'hFFFF, 16'h0004, 16'h2211, 16'h1234, 16'h1122, 16'h3412};
        vecs[2] = {16'h0004, 16'h0005, 16'h1234, 16'h7712, 16'h3412, 16'h1277};
        vecs[3] = {16'h0009, 16'h0008, 16'h3CAB, 16'hABCD, 16'hAB3C, 16'hCDAB};
        vecs[4] = {16'h0002, 16'h0002, 16'hA55A, 16'hA55A, 16'h5AA5, 16'h5AA5};

        rst_n     = 1'b0;
        req_valid = 1'b0;
        op_ready  = 1'b0;
        src1_addr = '0;
        src2_addr = '0;
        mem_rdata = '0;

        @(negedge clk);
        chk1("rst_req_ready", req_ready, 1'b1);
        chk1("rst_mem_rd", mem_rd, 1'b0);
        chk16("rst_mem_addr", mem_addr, 16'h0000);
        chk1("rst_op_valid", op_valid, 1'b0);
        chk16("rst_op1", op1, 16'h0000);
        chk16("rst_op2", op2, 16'h0000);
        rst_n = 1'b1;

        // Reset while in A2L, between clock edges.
        issue(vecs[0]);
        repeat (3) @(negedge clk);
        chk16("pre_rst_op1_byte0", op1, 16'h0034);
        #2 rst_n = 1'b0;
        #1;
        chk1("arst_mem_rd", mem_rd, 1'b0);
        chk1("arst_op_valid", op_valid, 1'b0);
        chk1("arst_req_ready", req_ready, 1'b1);
        chk16("arst_op1", op1, 16'h0000);
        chk16("arst_op2", op2, 16'h0000);
        chk16("arst_be_op1", be_op1, 16'h0000);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // Table of requests; the first holds 10 cycles of backpressure, the
        // last pair runs back-to-back.
        for (int i = 0; i < 4; i++) begin
            issue(vecs[i]);
            follow(vecs[i], (i == 0) ? 10 : 0);
            if (i < 3) transfer();
        end
        back_to_back(vecs[4]);
        follow(vecs[4], 0);
        transfer();

        chk16("sb_drained", 16'(sb.size()), 16'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
